multiseg_display: RTL and testbench

//  Avalon-MM slave driving NUM_DIGITS seven-segment digits. Each digit holds either a raw

---
 rtl/multiseg_pkg.sv | 26 ++
 rtl/multiseg_display_seg_hex_decoder.sv | 12 +
 rtl/multiseg_display.sv | 161 ++++++++++++++++
 tb/tb_multiseg_display.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/multiseg_pkg.sv
// Shared register map, CTRL bit positions and hex segment table for multiseg_display.
// Define MULTISEG_DP_EN to widen each digit to 8 segments, with the decimal point in bit 7.
package multiseg_pkg;

`ifdef MULTISEG_DP_EN
  localparam int SEG_W = 8;
`else
  localparam int SEG_W = 7;
`endif

  localparam int ADDR_CTRL       = 0;
  localparam int ADDR_BLINK      = 1;
  localparam int ADDR_DIGIT_BASE = 2;

  localparam int CTRL_HEX     = 0;
  localparam int CTRL_BLANK   = 1;
  localparam int CTRL_SCAN_EN = 2;
  localparam int CTRL_W       = 3;

  // Segment bit order is g..a = [6:0].
  localparam logic [6:0] HEX_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/multiseg_display_seg_hex_decoder.sv
// Combinational nibble to seven-segment pattern lookup.
// Bit order is g..a = [6:0]; this block never drives the decimal point.
module seg_hex_decoder
  import multiseg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_TABLE[nibble];

endmodule

// File: rtl/multiseg_display.sv
// Avalon-MM seven-segment controller with hex decode, per-digit blink, blanking and a scan output.
// Define MULTISEG_DP_EN to add a stored decimal-point bit (DIGIT[7]) to every digit.
module multiseg_display
  import multiseg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int ADDR_WIDTH     = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int BLINK_DIV      = 25000000,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [ADDR_WIDTH-1:0]       slave_address,
  input  logic                        slave_read,
  input  logic                        slave_write,
  input  logic [31:0]                 slave_writedata,
  input  logic [3:0]                  slave_byteenable,
  output logic [31:0]                 slave_readdata,
  output logic [NUM_DIGITS*SEG_W-1:0] seg_static,
  output logic [SEG_W-1:0]            seg_scan,
  output logic [NUM_DIGITS-1:0]       dig_sel
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PRE_W = $clog2(SCAN_DIV);
  localparam int BLK_W = $clog2(BLINK_DIV);

  logic [CTRL_W-1:0]     ctrl_q;
  logic [NUM_DIGITS-1:0] blink_q;
  logic [SEG_W-1:0]      digit_q [NUM_DIGITS];
  logic [31:0]           rd_data;
  logic [31:0]           readdata_p1;

  logic [PRE_W-1:0]      pre_q;
  logic [IDX_W-1:0]      idx_q;
  logic [BLK_W-1:0]      blk_cnt_q;
  logic                  blink_phase_q;

  logic [6:0]            hex_seg  [NUM_DIGITS];
  logic [6:0]            body     [NUM_DIGITS];
  logic [SEG_W-1:0]      pat      [NUM_DIGITS];
  logic [NUM_DIGITS*SEG_W-1:0] seg_static_d;
  logic [NUM_DIGITS*SEG_W-1:0] seg_static_p1;
  logic [SEG_W-1:0]      seg_scan_p1;
  logic [NUM_DIGITS-1:0] dig_sel_p1;

  logic unused_ok;
  assign unused_ok = ^{slave_writedata, slave_byteenable};

  // ---- bus write: register file ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q  <= '0;
      blink_q <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) digit_q[i] <= '0;
    end else if (slave_write) begin
      if (slave_address == ADDR_WIDTH'(ADDR_CTRL) && slave_byteenable[0])
        ctrl_q <= slave_writedata[CTRL_W-1:0];
      if (slave_address == ADDR_WIDTH'(ADDR_BLINK)) begin
        // The mask can cross into lane 1 once there are more than 8 digits.
        for (int i = 0; i < NUM_DIGITS; i++)
          if (slave_byteenable[i/8]) blink_q[i] <= slave_writedata[i];
      end
      for (int i = 0; i < NUM_DIGITS; i++)
        if (slave_address == ADDR_WIDTH'(ADDR_DIGIT_BASE + i) && slave_byteenable[0])
          digit_q[i] <= slave_writedata[SEG_W-1:0];
    end
  end

  // ---- bus read: mux from current registers, one-cycle latency ----
  always_comb begin
    rd_data = '0;
    if (slave_address == ADDR_WIDTH'(ADDR_CTRL))
      rd_data[CTRL_W-1:0] = ctrl_q;
    if (slave_address == ADDR_WIDTH'(ADDR_BLINK))
      rd_data[NUM_DIGITS-1:0] = blink_q;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (slave_address == ADDR_WIDTH'(ADDR_DIGIT_BASE + i))
        rd_data[SEG_W-1:0] = digit_q[i];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        readdata_p1 <= '0;
    else if (slave_read) readdata_p1 <= rd_data;
  end

  assign slave_readdata = readdata_p1;

  // ---- blink timebase ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blk_cnt_q     <= '0;
      blink_phase_q <= 1'b0;
    end else if (blk_cnt_q == BLK_W'(BLINK_DIV - 1)) begin
      blk_cnt_q     <= '0;
      blink_phase_q <= ~blink_phase_q;
    end else begin
      blk_cnt_q     <= blk_cnt_q + BLK_W'(1);
    end
  end

  // ---- display pattern per digit ----
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    seg_hex_decoder u_dec (
      .nibble (digit_q[g][3:0]),
      .seg    (hex_seg[g])
    );
  end

  always_comb begin
    seg_static_d = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      body[i] = ctrl_q[CTRL_HEX] ? hex_seg[i] : digit_q[i][6:0];
`ifdef MULTISEG_DP_EN
      pat[i]  = {digit_q[i][7], body[i]};
`else
      pat[i]  = body[i];
`endif
      if (ctrl_q[CTRL_BLANK] || (blink_phase_q && blink_q[i]))
        pat[i] = '0;
      seg_static_d[i*SEG_W +: SEG_W] = pat[i];
    end
  end

  // ---- static output register ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) seg_static_p1 <= '0;
    else          seg_static_p1 <= seg_static_d;
  end

  // ---- scan prescaler, digit index and scan output register ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_q       <= '0;
      idx_q       <= '0;
      seg_scan_p1 <= '0;
      dig_sel_p1  <= '0;
    end else if (!ctrl_q[CTRL_SCAN_EN]) begin
      pre_q       <= '0;
      idx_q       <= '0;
      seg_scan_p1 <= '0;
      dig_sel_p1  <= '0;
    end else begin
      if (pre_q == PRE_W'(SCAN_DIV - 1)) begin
        pre_q <= '0;
        idx_q <= (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
      end else begin
        pre_q <= pre_q + PRE_W'(1);
      end
      seg_scan_p1 <= pat[idx_q];
      dig_sel_p1  <= NUM_DIGITS'(1) << idx_q;
    end
  end

  // Internal state is active-high; polarity is applied only at the pins.
  assign seg_static = seg_static_p1 ^ {(NUM_DIGITS*SEG_W){SEG_ACTIVE_LOW}};
  assign seg_scan   = seg_scan_p1   ^ {SEG_W{SEG_ACTIVE_LOW}};
  assign dig_sel    = dig_sel_p1    ^ {NUM_DIGITS{SEG_ACTIVE_LOW}};

endmodule

// File: tb/tb_multiseg_display.sv
// Directed self-checking bench for multiseg_display (default build, 4 digits, active-high pins).
`timescale 1ns/1ps
module tb_multiseg_display;
  import multiseg_pkg::*;

  localparam int ND = 4;
  localparam int AW = 4;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic [AW-1:0]        slave_address = '0;
  logic                 slave_read = 1'b0;
  logic                 slave_write = 1'b0;
  logic [31:0]          slave_writedata = '0;
  logic [3:0]           slave_byteenable = '0;
  logic [31:0]          slave_readdata;
  logic [ND*SEG_W-1:0]  seg_static;
  logic [SEG_W-1:0]     seg_scan;
  logic [ND-1:0]        dig_sel;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multiseg_display #(
    .NUM_DIGITS     (ND),
    .ADDR_WIDTH     (AW),
    .SCAN_DIV       (4),
    .BLINK_DIV      (8),
    .SEG_ACTIVE_LOW (1'b0)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .slave_address    (slave_address),
    .slave_read       (slave_read),
    .slave_write      (slave_write),
    .slave_writedata  (slave_writedata),
    .slave_byteenable (slave_byteenable),
    .slave_readdata   (slave_readdata),
    .seg_static       (seg_static),
    .seg_scan         (seg_scan),
    .dig_sel          (dig_sel)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One bus cycle, driven between falling edges; read data sampled after the capturing edge.
  task automatic bus(input logic rd, input logic wr, input logic [AW-1:0] addr,
                     input logic [31:0] wd, input logic [3:0] be, output logic [31:0] rdata);
    @(negedge clk);
    slave_address    = addr;
    slave_read       = rd;
    slave_write      = wr;
    slave_writedata  = wd;
    slave_byteenable = be;
    @(negedge clk);
    slave_read  = 1'b0;
    slave_write = 1'b0;
    rdata = slave_readdata;
  endtask

  task automatic wr(input logic [AW-1:0] addr, input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] dummy;
    bus(1'b0, 1'b1, addr, wd, be, dummy);
  endtask

  task automatic rd(input logic [AW-1:0] addr, output logic [31:0] data);
    bus(1'b1, 1'b0, addr, 32'h0, 4'h0, data);
  endtask

  function automatic logic [6:0] fld(input int i);
    return seg_static[i*SEG_W +: 7];
  endfunction

  initial begin
    logic [31:0] r;
    logic [6:0]  scan_exp [4];
    logic [6:0]  prev, v1;
    logic [3:0]  oh;
    int          found, n;

    scan_exp = '{7'h77, 7'h4F, 7'h6D, 7'h71};

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_seg_static", 32'(seg_static), 32'h0);
    check_eq("rst_seg_scan", 32'(seg_scan), 32'h0);
    check_eq("rst_dig_sel", 32'(dig_sel), 32'h0);
    check_eq("rst_readdata", slave_readdata, 32'h0);
    reset_n = 1'b1;
    for (int a = 0; a < 7; a++) begin
      rd(AW'(a), r);
      check_eq("rst_read", r, 32'h0);
    end

    // Hex decode and static output latency
    wr(4'd0, 32'h1, 4'h1);
    wr(4'd2, 32'hA, 4'h1);
    check_eq("seg0_before_latency", 32'(fld(0)), 32'h3F);
    @(negedge clk);
    check_eq("seg0_hexA", 32'(fld(0)), 32'h77);
    wr(4'd3, 32'h3, 4'h1);
    @(negedge clk);
    check_eq("seg_all_hex", 32'(seg_static), 32'({7'h3F, 7'h3F, 7'h4F, 7'h77}));

    // Byte enables, masking, unmapped access, read-during-write
    wr(4'd2, 32'h7F, 4'h0);
    rd(4'd2, r);
    check_eq("digit0_be0", r, 32'hA);
    wr(4'd1, 32'hFFFF, 4'h3);
    rd(4'd1, r);
    check_eq("blink_mask", r, 32'hF);
    wr(4'd1, 32'h0, 4'h2);
    rd(4'd1, r);
    check_eq("blink_lane1_only", r, 32'hF);
    wr(4'd5, 32'hFF, 4'h1);
    rd(4'd5, r);
    check_eq("digit3_bit7", r, 32'h7F);
    wr(4'd7, 32'h5, 4'h1);
    rd(4'd7, r);
    check_eq("unmapped_read", r, 32'h0);
    bus(1'b1, 1'b1, 4'd4, 32'h5, 4'h1, r);
    check_eq("rw_same_old", r, 32'h0);
    rd(4'd4, r);
    check_eq("rw_same_new", r, 32'h5);
    rd(4'd0, r);
    check_eq("ctrl_read", r, 32'h1);
    wr(4'd1, 32'h0, 4'h3);

    // Scan sequence
    wr(4'd0, 32'h5, 4'h1);
    check_eq("scan_pre_enable", 32'(dig_sel), 32'h0);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      oh = 4'b0001 << (((k - 1) / 4) % 4);
      check_eq("scan_dig_sel", 32'(dig_sel), 32'(oh));
      check_eq("scan_seg", 32'(seg_scan), 32'(scan_exp[((k - 1) / 4) % 4]));
    end
    wr(4'd0, 32'h1, 4'h1);
    @(negedge clk);
    check_eq("scan_off_dig_sel", 32'(dig_sel), 32'h0);
    check_eq("scan_off_seg", 32'(seg_scan), 32'h0);

    // Blink on digit 1 only
    wr(4'd0, 32'h0, 4'h1);
    wr(4'd3, 32'h3F, 4'h1);
    wr(4'd1, 32'h2, 4'h3);
    repeat (2) @(negedge clk);
    prev  = fld(1);
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      @(negedge clk);
      if (fld(1) != prev) found = 1;
    end
    check_eq("blink_first_edge", 32'(found), 32'h1);
    v1 = fld(1);
    check_eq("blink_value_a", 32'(v1 == 7'h3F || v1 == 7'h00), 32'h1);
    n = 0;
    for (int k = 1; k <= 20 && n == 0; k++) begin
      @(negedge clk);
      if (fld(1) != v1) n = k;
    end
    check_eq("blink_half_period", 32'(n), 32'd8);
    check_eq("blink_value_b", 32'(fld(1)), 32'(v1 ^ 7'h3F));
    check_eq("blink_digit0_steady", 32'(fld(0)), 32'h0A);
    check_eq("blink_digit3_steady", 32'(fld(3)), 32'h7F);
    wr(4'd0, 32'h2, 4'h1);
    @(negedge clk);
    check_eq("blank_all", 32'(seg_static), 32'h0);
    wr(4'd0, 32'h0, 4'h1);
    wr(4'd1, 32'h0, 4'h3);

    // Reset in the middle of a scan
    wr(4'd0, 32'h4, 4'h1);
    found = 0;
    for (int k = 0; k < 40 && found == 0; k++) begin
      @(negedge clk);
      if (dig_sel == 4'b0100) found = 1;
    end
    check_eq("reach_index2", 32'(found), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    check_eq("midrst_dig_sel", 32'(dig_sel), 32'h0);
    check_eq("midrst_seg_static", 32'(seg_static), 32'h0);
    check_eq("midrst_readdata", slave_readdata, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    wr(4'd0, 32'h4, 4'h1);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      oh = (k <= 4) ? 4'b0001 : 4'b0010;
      check_eq("restart_dig_sel", 32'(dig_sel), 32'(oh));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
